// File: rtl/add8_err_monitor.sv
// add8_err_monitor
//   Error-characterisation engine for W-bit approximate adders. The block
//   sweeps every operand pair {A,B} into an external combinational adder,
//   captures the result O and compares it against the exact sum. It builds up
//   the library error metrics for the whole sweep:
//     abs_sum_o : sum of |exact - O|        (MAE numerator)
//     sq_sum_o  : sum of (exact - O)^2      (MSE numerator)
//     wce_o     : max |exact - O|           (worst-case error)
//     err_cnt_o : count of pairs, O != exact (EP numerator)
//
// Ports
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   start_i     : one-cycle pulse; starts a sweep from IDLE or DONE
//   hold_i      : pauses the sweep (the pipeline keeps draining)
//   A, B        : operands driven to the adder under test (registered)
//   O           : adder result, combinational from A/B
//   busy_o      : high while a sweep or its drain is in progress
//   done_o      : one-cycle pulse when the metrics are final
//   abs_sum_o, sq_sum_o, wce_o, err_cnt_o : accumulated metrics
//
// Timing with no hold: start sampled at edge 0, pair 0 on A/B in cycle 1,
// last pair in cycle 2^(2W), done_o in cycle 2^(2W)+3.
module add8_err_monitor #(
  parameter int W    = 8,
  parameter int ERRW = W + 1,
  parameter int SUMW = 3 * W + 1,
  parameter int SQW  = 4 * W + 2,
  parameter int CNTW = 2 * W + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            hold_i,
  output logic [W-1:0]    A,
  output logic [W-1:0]    B,
  input  logic [W:0]      O,
  output logic            busy_o,
  output logic            done_o,
  output logic [SUMW-1:0] abs_sum_o,
  output logic [SQW-1:0]  sq_sum_o,
  output logic [ERRW-1:0] wce_o,
  output logic [CNTW-1:0] err_cnt_o
);

  localparam int STAGES = 2;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  // Stage 1: raw sample from the adder interface.
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   o;
  } s1_t;

  // Stage 2: per-sample error terms ready for accumulation.
  typedef struct packed {
    logic [ERRW-1:0]   abs_err;
    logic [2*ERRW-1:0] sq_err;
    logic              neq;
  } s2_t;

  state_t          state;
  logic [2*W-1:0]  pair_cnt;
  logic [1:0]      drain_cnt;
  logic            sample;
  logic            accept;
  logic [STAGES:1] vld_pipe;
  s1_t             s1;
  s2_t             s2;
  s2_t             s2_next;

  // Operands come straight from the pair counter so they are glitch-free
  // and stay stable while the sweep is held.
  assign A = pair_cnt[2*W-1:W];
  assign B = pair_cnt[W-1:0];

  // A sample is taken on every un-held SWEEP cycle; the counter advances on
  // exactly the same condition, so each pair is sampled once.
  assign sample = (state == SWEEP) && !hold_i;
  assign accept = start_i && ((state == IDLE) || (state == DONE));

  // ---------------------------------------------------------------------
  // Control FSM with registered busy/done
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pair_cnt  <= '0;
      drain_cnt <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state    <= SWEEP;
            pair_cnt <= '0;
            busy_o   <= 1'b1;
          end
        end
        SWEEP: begin
          if (!hold_i) begin
            pair_cnt <= pair_cnt + (2*W)'(1);
            // Last pair sampled this cycle; counter wraps back to 0.
            if (&pair_cnt) begin
              state     <= DRAIN;
              drain_cnt <= '0;
            end
          end
        end
        DRAIN: begin
          // Two cycles: the last sample moves S1->S2, then S2->accumulators.
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == 2'd1) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2 arithmetic: exact sum, signed difference, magnitude, square
  // ---------------------------------------------------------------------
  logic [W:0]          exact;
  logic signed [W+1:0] diff;

  always_comb begin
    exact   = {1'b0, s1.a} + {1'b0, s1.b};
    // One extra bit on both sides so exact - O never wraps.
    diff    = $signed({1'b0, exact}) - $signed({1'b0, s1.o});
    s2_next = '0;
    s2_next.abs_err = diff[W+1] ? ERRW'(-diff) : ERRW'(diff);
    s2_next.sq_err  = {{ERRW{1'b0}}, s2_next.abs_err} *
                      {{ERRW{1'b0}}, s2_next.abs_err};
    s2_next.neq     = (diff != '0);
  end

  // ---------------------------------------------------------------------
  // Pipeline registers and accumulators
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      s1        <= '0;
      s2        <= '0;
      abs_sum_o <= '0;
      sq_sum_o  <= '0;
      wce_o     <= '0;
      err_cnt_o <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], sample};
      if (sample)      s1 <= '{a: A, b: B, o: O};
      if (vld_pipe[1]) s2 <= s2_next;

      // The pipeline is empty in IDLE/DONE, so a clear on start cannot
      // collide with an in-flight accumulation.
      if (accept) begin
        abs_sum_o <= '0;
        sq_sum_o  <= '0;
        wce_o     <= '0;
        err_cnt_o <= '0;
      end else if (vld_pipe[2]) begin
        abs_sum_o <= abs_sum_o + SUMW'(s2.abs_err);
        sq_sum_o  <= sq_sum_o + SQW'(s2.sq_err);
        err_cnt_o <= err_cnt_o + CNTW'(s2.neq);
        if (s2.abs_err > wce_o) wce_o <= s2.abs_err;
      end
    end
  end

endmodule

// File: tb/tb_add8_err_monitor.sv
// Bench for add8_err_monitor. Two instances share clock and reset: a W=8
// instance for one full-size sweep plus the mid-sweep reset case, and a W=4
// instance (256 pairs) for the per-adder-model runs and random hold runs.
// Expected metrics come from a plain arithmetic loop over all operand pairs.
module tb_add8_err_monitor;

  typedef struct packed {
    longint abs_sum;
    longint sq_sum;
    longint wce;
    longint cnt;
  } metrics_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   failed = 0;

  // W=8 instance signals
  logic        start8, hold8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [8:0]  o8;
  logic [24:0] abs8;
  logic [33:0] sq8;
  logic [8:0]  wce8;
  logic [16:0] cnt8;
  int          mode8;

  // W=4 instance signals
  logic        start4, hold4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [4:0]  o4;
  logic [12:0] abs4;
  logic [17:0] sq4;
  logic [4:0]  wce4;
  logic [8:0]  cnt4;
  int          mode4;

  always #5 clk = ~clk;

  // Adder models: 0 exact, 1 stuck-zero, 2 off-by-one, 3 LSB forced to 1.
  function automatic int adder_out(input int mode, input int a, input int b);
    case (mode)
      1:       return 0;
      2:       return a + b + 1;
      3:       return (a + b) | 1;
      default: return a + b;
    endcase
  endfunction

  always_comb o8 = 9'(adder_out(mode8, int'(a8), int'(b8)));
  always_comb o4 = 5'(adder_out(mode4, int'(a4), int'(b4)));

  function automatic metrics_t ref_metrics(input int w, input int mode);
    metrics_t m;
    longint d, ad;
    m = '0;
    for (int a = 0; a < (1 << w); a++)
      for (int b = 0; b < (1 << w); b++) begin
        d  = longint'(a + b) - longint'(adder_out(mode, a, b));
        ad = (d < 0) ? -d : d;
        m.abs_sum += ad;
        m.sq_sum  += ad * ad;
        if (ad > m.wce) m.wce = ad;
        if (d != 0) m.cnt++;
      end
    return m;
  endfunction

  add8_err_monitor #(.W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .hold_i(hold8),
    .A(a8), .B(b8), .O(o8), .busy_o(busy8), .done_o(done8),
    .abs_sum_o(abs8), .sq_sum_o(sq8), .wce_o(wce8), .err_cnt_o(cnt8)
  );

  add8_err_monitor #(.W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(start4), .hold_i(hold4),
    .A(a4), .B(b4), .O(o4), .busy_o(busy4), .done_o(done4),
    .abs_sum_o(abs4), .sq_sum_o(sq4), .wce_o(wce4), .err_cnt_o(cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      failed++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One W=4 sweep. With rnd set, hold is also high on the start cycle and
  // then random (~30%) every cycle, including the drain where it is ignored.
  task automatic run4(input string tag, input int mode, input bit rnd);
    metrics_t m;
    int  taken, held, done_cyc, ab_err, busy_err;
    bit  h;
    taken = 0; held = 0; done_cyc = -1; ab_err = 0; busy_err = 0;
    mode4 = mode;
    m = ref_metrics(4, mode);
    @(negedge clk); start4 = 1'b1; hold4 = rnd;
    @(negedge clk); start4 = 1'b0;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      if (done4) begin done_cyc = cyc; break; end
      if (!busy4) busy_err++;
      h = rnd && ($urandom_range(0, 9) < 3);
      if (taken < 256) begin
        if ({a4, b4} !== 8'(taken)) ab_err++;
        if (h) held++; else taken++;
      end
      hold4 = h;
      @(negedge clk);
    end
    hold4 = 1'b0;
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(259 + held));
    chk({tag, "_ab_seq_errs"}, 64'(ab_err), 64'd0);
    chk({tag, "_busy_gaps"}, 64'(busy_err), 64'd0);
    chk({tag, "_busy_at_done"}, 64'(busy4), 64'd0);
    chk({tag, "_abs_sum"}, 64'(abs4), m.abs_sum);
    chk({tag, "_sq_sum"}, 64'(sq4), m.sq_sum);
    chk({tag, "_wce"}, 64'(wce4), m.wce);
    chk({tag, "_err_cnt"}, 64'(cnt4), m.cnt);
    @(negedge clk);
    chk({tag, "_done_pulse_end"}, 64'(done4), 64'd0);
    chk({tag, "_abs_sum_hold"}, 64'(abs4), m.abs_sum);
  endtask

  initial begin
    int taken, done_cyc, ab_err, busy_err, extra_done;
    bit reached;
    rst_n = 1'b1;
    start8 = 1'b0; hold8 = 1'b0; start4 = 1'b0; hold4 = 1'b0;
    mode8 = 0; mode4 = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_a8", 64'(a8), 64'd0);
    chk("rst_b8", 64'(b8), 64'd0);
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_abs8", 64'(abs8), 64'd0);
    chk("rst_sq8", 64'(sq8), 64'd0);
    chk("rst_wce8", 64'(wce8), 64'd0);
    chk("rst_cnt8", 64'(cnt8), 64'd0);
    chk("rst_busy4", 64'(busy4), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run4("exact", 0, 1'b0);
    run4("stuck0", 1, 1'b0);
    run4("offby1", 2, 1'b0);
    run4("lsb1", 3, 1'b0);
    run4("offby1_hold", 2, 1'b1);
    run4("exact_hold", 0, 1'b1);
    run4("lsb1_hold", 3, 1'b1);

    // W=8: stuck-zero sweep interrupted by reset at pair 1000.
    mode8 = 1;
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    reached = 1'b0;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      if ({a8, b8} === 16'd1000) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    chk("reach_pair_1000", 64'(reached), 64'd1);
    chk("busy_before_rst", 64'(busy8), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_a8", 64'(a8), 64'd0);
    chk("midrst_b8", 64'(b8), 64'd0);
    chk("midrst_busy8", 64'(busy8), 64'd0);
    chk("midrst_done8", 64'(done8), 64'd0);
    chk("midrst_abs8", 64'(abs8), 64'd0);
    chk("midrst_sq8", 64'(sq8), 64'd0);
    chk("midrst_wce8", 64'(wce8), 64'd0);
    chk("midrst_cnt8", 64'(cnt8), 64'd0);
    chk("midrst_abs4_cleared", 64'(abs4), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle_busy8", 64'(busy8), 64'd0);

    // Fresh full W=8 sweep; a stray start in cycle 500 must be ignored.
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    taken = 0; done_cyc = -1; ab_err = 0; busy_err = 0;
    for (int cyc = 1; cyc <= 70000; cyc++) begin
      if (done8) begin done_cyc = cyc; break; end
      if (!busy8) busy_err++;
      if (taken < 65536) begin
        if ({a8, b8} !== 16'(taken)) ab_err++;
        taken++;
      end
      start8 = (cyc == 500);
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("w8_done_cycle", 64'(done_cyc), 64'd65539);
    chk("w8_ab_seq_errs", 64'(ab_err), 64'd0);
    chk("w8_busy_gaps", 64'(busy_err), 64'd0);
    chk("w8_busy_at_done", 64'(busy8), 64'd0);
    chk("w8_abs_sum", 64'(abs8), 64'd16711680);
    chk("w8_sq_sum", 64'(sq8), 64'd4977295360);
    chk("w8_wce", 64'(wce8), 64'd510);
    chk("w8_err_cnt", 64'(cnt8), 64'd65535);
    extra_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done8) extra_done++;
    end
    chk("w8_single_done", 64'(extra_done), 64'd0);
    chk("w8_sq_sum_hold", 64'(sq8), 64'd4977295360);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
